// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled 8N1 deserializer with rda/frame_err/overrun status.
// Latency: rda rises 1 clk after the stop-bit sample (151 ticks after start detect); no backpressure, unread bytes are overwritten.
module spart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] divisor,
  input  logic        rd_ack,
  output logic [7:0]  rx_data,
  output logic        rda,
  output logic        frame_err,
  output logic        overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              rxd_s;
  logic [15:0]       tick_cnt;
  logic              tick;
  logic [SW-1:0]     sample_cnt, sample_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        shift, shift_n;
  logic              stop_q, stop_n;
  logic              done_q, done_n;
  logic              armed, armed_n;

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign tick  = (tick_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '1;
      tick_cnt <= divisor;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
      tick_cnt <= tick ? divisor : tick_cnt - 16'd1;
    end
  end

  always_comb begin
    state_n  = state;
    sample_n = sample_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    stop_n   = stop_q;
    done_n   = 1'b0;
    armed_n  = armed | rxd_s;
    if (tick) begin
      case (state)
        IDLE: begin
          // The detection tick is sample 0 of the start bit.
          if (!rxd_s && armed) begin
            state_n  = START;
            sample_n = SW'(1);
          end
        end
        START: begin
          if (sample_cnt == MID) begin
            sample_n = '0;
            bit_n    = 3'd0;
            state_n  = rxd_s ? IDLE : DATA;
          end else begin
            sample_n = sample_cnt + 1'b1;
          end
        end
        DATA: begin
          if (sample_cnt == LAST) begin
            shift_n  = {rxd_s, shift[7:1]};
            bit_n    = bit_cnt + 3'd1;
            sample_n = '0;
            if (bit_cnt == 3'd7) state_n = STOP;
          end else begin
            sample_n = sample_cnt + 1'b1;
          end
        end
        STOP: begin
          if (sample_cnt == LAST) begin
            stop_n   = rxd_s;
            done_n   = 1'b1;
            state_n  = IDLE;
            // A low stop bit (e.g. break) must see the line go high before re-arming.
            armed_n  = rxd_s;
            sample_n = '0;
          end else begin
            sample_n = sample_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      stop_q     <= 1'b1;
      done_q     <= 1'b0;
      armed      <= 1'b1;
    end else begin
      state      <= state_n;
      sample_cnt <= sample_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      stop_q     <= stop_n;
      done_q     <= done_n;
      armed      <= armed_n;
    end
  end

  // A completing byte always wins over a simultaneous rd_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= 8'd0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done_q) begin
      rx_data   <= shift;
      frame_err <= ~stop_q;
      rda       <= 1'b1;
      overrun   <= rda & ~rd_ack;
    end else if (rd_ack && rda) begin
      rda       <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: expected frames queued at send time, popped when the byte is visible.
module tb_spart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [15:0] divisor;
  logic        rd_ack;
  logic [7:0]  rx_data;
  logic        rda;
  logic        frame_err;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];

  spart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .divisor   (divisor),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (bclk) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = d[i];
      repeat (bclk) @(posedge clk);
    end
    #1 rxd = stop;
    repeat (bclk) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  task automatic wait_rda(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rda) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 rd_ack = 1'b1;
    @(posedge clk);
    #1 rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0; rxd = 1'b1; rd_ack = 1'b0; divisor = 16'd0;
    #23;
    total++;
    if ({rx_data, rda, frame_err, overrun} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b exp=00/0/0/0", rx_data, rda, frame_err, overrun);
    end
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
  endtask

  task automatic test_basic();
    int lat;
    bit seen;
    exp_t e;
    divisor = 16'd0;
    sb.push_back('{8'hA6, 1'b0, 1'b0});
    lat = 0;
    fork
      send_frame(8'hA6, 1'b1, 16);
      begin
        @(posedge clk);
        for (int i = 0; i < 400; i++) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (rda) break;
        end
      end
    join
    total++;
    if (lat < 153 || lat > 156) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=153..156", lat);
    end
    wait_rda(50, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL basic_rda got=0 exp=1");
    end
    e = sb.pop_front();
    total++;
    if ({rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL basic_frame got=%h/%b/%b exp=%h/%b/%b", rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
    total++;
    if (rda !== 1'b0) begin
      bad++;
      $display("FAIL basic_ack_clears_rda got=%b exp=0", rda);
    end
  endtask

  task automatic test_slow();
    int early;
    bit seen;
    exp_t e;
    divisor = 16'd3;
    repeat (20) @(posedge clk);
    sb.push_back('{8'h59, 1'b0, 1'b0});
    early = 0;
    fork
      send_frame(8'h59, 1'b1, 64);
      begin
        @(posedge clk);
        repeat (9 * 64) begin
          @(negedge clk);
          if (rda) early++;
        end
      end
    join
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL slow_rda_during_frame got=%0d high cycles exp=0", early);
    end
    wait_rda(100, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL slow_rda got=0 exp=1");
    end
    e = sb.pop_front();
    total++;
    if ({rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL slow_frame got=%h/%b/%b exp=%h/%b/%b", rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
    divisor = 16'd0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_false_start();
    int highs;
    bit seen;
    exp_t e;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    highs = 0;
    repeat (300) begin
      @(negedge clk);
      if (rda) highs++;
    end
    total++;
    if (highs != 0) begin
      bad++;
      $display("FAIL false_start_rda got=%0d high cycles exp=0", highs);
    end
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b1, 16);
    wait_rda(50, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL false_start_next_rda got=0 exp=1");
    end
    e = sb.pop_front();
    total++;
    if ({rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL false_start_next_frame got=%h/%b/%b exp=%h/%b/%b", rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
  endtask

  task automatic test_framing();
    bit seen;
    exp_t e;
    sb.push_back('{8'h81, 1'b1, 1'b0});
    send_frame(8'h81, 1'b0, 16);
    wait_rda(50, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL frame_err_frame got=%b %h/%b/%b exp=1 %h/%b/%b", seen, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL frame_err_sticky_over_ack got=%b exp=1", frame_err);
    end
    repeat (20) @(posedge clk);
    sb.push_back('{8'h55, 1'b0, 1'b0});
    send_frame(8'h55, 1'b1, 16);
    wait_rda(50, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL frame_err_clear got=%b %h/%b/%b exp=1 %h/%b/%b", seen, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    bit seen;
    exp_t e;
    sb.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b1, 16);
    wait_rda(50, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL overrun_first got=%b %h/%b/%b exp=1 %h/%b/%b", seen, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    sb.push_back('{8'h22, 1'b0, 1'b1});
    send_frame(8'h22, 1'b1, 16);
    repeat (10) @(negedge clk);
    e = sb.pop_front();
    total++;
    if (rda !== 1'b1 || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL overrun_second got=%b %h/%b/%b exp=1 %h/%b/%b", rda, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
    total++;
    if ({rda, overrun} !== 2'b00) begin
      bad++;
      $display("FAIL overrun_ack got=%b%b exp=00", rda, overrun);
    end
  endtask

  task automatic test_ack_collision();
    bit seen;
    exp_t e;
    sb.push_back('{8'h33, 1'b0, 1'b0});
    send_frame(8'h33, 1'b1, 16);
    wait_rda(50, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL collision_first got=%b %h/%b/%b exp=1 %h/%b/%b", seen, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    sb.push_back('{8'h44, 1'b0, 1'b0});
    fork
      send_frame(8'h44, 1'b1, 16);
      begin
        @(posedge clk);
        #1;
        repeat (154) @(posedge clk);
        #1 rd_ack = 1'b1;
        @(posedge clk);
        #1 rd_ack = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    e = sb.pop_front();
    total++;
    if (rda !== 1'b1 || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL collision_new_wins got=%b %h/%b/%b exp=1 %h/%b/%b", rda, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
  endtask

  task automatic test_break();
    bit seen;
    int highs;
    exp_t e;
    sb.push_back('{8'h00, 1'b1, 1'b0});
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (rda !== 1'b1 || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL break_frame got=%b %h/%b/%b exp=1 %h/%b/%b", rda, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
    pulse_ack();
    highs = 0;
    repeat (400) begin
      @(negedge clk);
      if (rda) highs++;
    end
    total++;
    if (highs != 0) begin
      bad++;
      $display("FAIL break_held_rda got=%0d high cycles exp=0", highs);
    end
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    sb.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b1, 16);
    wait_rda(50, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL break_recover got=%b %h/%b/%b exp=1 %h/%b/%b", seen, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
  endtask

  task automatic test_reset_mid_frame();
    int highs;
    bit seen;
    exp_t e;
    highs = 0;
    fork
      send_frame(8'hF0, 1'b1, 16);
      begin
        @(posedge clk);
        #1;
        repeat (16 * 5 + 8) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total++;
        if ({rx_data, rda, frame_err, overrun} !== 11'd0) begin
          bad++;
          $display("FAIL reset_async got=%h/%b/%b/%b exp=00/0/0/0", rx_data, rda, frame_err, overrun);
        end
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
      end
    join
    repeat (200) begin
      @(negedge clk);
      if (rda) highs++;
    end
    total++;
    if (highs != 0) begin
      bad++;
      $display("FAIL reset_no_partial got=%0d high cycles exp=0", highs);
    end
    sb.push_back('{8'h0F, 1'b0, 1'b0});
    send_frame(8'h0F, 1'b1, 16);
    wait_rda(50, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {rx_data, frame_err, overrun} !== e) begin
      bad++;
      $display("FAIL reset_recover got=%b %h/%b/%b exp=1 %h/%b/%b", seen, rx_data, frame_err, overrun, e.data, e.ferr, e.ovr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow();
    test_false_start();
    test_framing();
    test_overrun();
    test_ack_collision();
    test_break();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
